// File: rtl/load_store_unit.sv
// Load/store unit: aligns byte/halfword/word accesses onto a 32-bit word memory,
// using read-modify-write for sub-word stores.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] buf_d;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [9:0]  mem_addr_q;
  logic [31:0] mem_din_q;

  logic        req_err_c;
  logic [31:0] merged_c;
  logic [31:0] load_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Misalignment, reserved size, or address outside the 4 KiB window.
  always_comb begin
    req_err_c = (req_size == SZ_RSVD)
             || (req_size == SZ_HALF && req_addr[0])
             || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
             || (req_addr[31:12] != 20'd0);
  end

  // Buffer value as it will be after this edge; READ captures the memory word.
  always_comb begin
    buf_d    = (state_q == READ) ? mem_dout : buf_q;
    merged_c = buf_d;
    byte_c   = buf_d[{lane_q, 3'b000} +: 8];
    half_c   = buf_d[{lane_q[1], 4'b0000} +: 16];
    load_c   = buf_d;
    case (size_q)
      SZ_BYTE: begin
        merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
      end
      SZ_HALF: begin
        merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        load_c = {{16{~uns_q & half_c[15]}}, half_c};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'd0;
      buf_q        <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 10'd0;
      mem_din_q    <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      buf_q        <= buf_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            mem_addr_q <= req_addr[11:2];
            if (req_err_c) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && req_size == SZ_WORD) begin
              mem_din_q <= req_wdata;
              state_q   <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            mem_din_q <= merged_c;
            state_q   <= WRITE;
          end else begin
            resp_rdata_q <= load_c;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WRITE: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  // Strobes are gated by reset so an in-flight access is cut immediately.
  assign mem_ren    = (state_q == READ) && !reset;
  assign mem_wen    = (state_q == WRITE) && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts every
// response; a monitor checks responses, latency and memory side effects.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_wen, mem_ren;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          touch;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          touch_cnt = 0;
  logic [31:0] last_rdata;
  logic [9:0]  last_waddr;
  logic [31:0] last_wdin;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain shift/mask arithmetic over the word array.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int unsigned idx, sh, width;
    logic [63:0] mask, word, v;
    e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd4096);
    e.rdata = 32'd0;
    e.lat = 1;
    e.acc = 0;
    e.touch = 0;
    if (!e.err) begin
      idx   = addr / 4;
      sh    = 8 * (addr % 4);
      width = 8 << size;
      mask  = (64'd1 << width) - 64'd1;
      word  = 64'(ref_mem[idx]);
      if (we) begin
        word = (word & ~(mask << sh)) | ((64'(wdata) & mask) << sh);
        ref_mem[idx] = word[31:0];
        e.lat = (width == 32) ? 3'd2 : 3'd3;
      end else begin
        v = (word >> sh) & mask;
        if (!uns && ((v >> (width - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        e.rdata = v[31:0];
        e.lat = 2;
      end
    end
    return e;
  endfunction

  always @(negedge clk) if (mem_ren || mem_wen) touch_cnt <= touch_cnt + 1;
  always @(negedge clk) if (mem_wen) begin last_waddr <= mem_addr; last_wdin <= mem_din; end

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_rdata = resp_rdata;
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_rdata", resp_rdata, e.rdata);
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
        if (e.err) check("err_no_mem_access", 32'(touch_cnt), 32'(e.touch));
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    if (push) begin
      e = model(we, size, uns, addr, wdata);
      e.acc = cyc;
      e.touch = touch_cnt;
      sb.push_back(e);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] saved, a;
    int nbad;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_mem_strobes", 32'({mem_ren, mem_wen}), 32'd0);
    reset = 1'b0;

    issue(1, 2'd2, 0, 32'h40, 32'h11223344, 1);
    drain();
    check("wr_addr", 32'(last_waddr), 32'd16);
    check("wr_din", last_wdin, 32'h11223344);
    issue(0, 2'd2, 0, 32'h40, 32'h0, 1);
    drain();
    check("load_word", last_rdata, 32'h11223344);
    issue(1, 2'd0, 0, 32'h42, 32'hAB, 1);
    drain();
    check("byte_store_din", last_wdin, 32'h11AB3344);
    check("byte_store_mem", mem[16], 32'h11AB3344);

    issue(1, 2'd2, 0, 32'h40, 32'h80223344, 1);
    issue(0, 2'd0, 0, 32'h43, 32'h0, 1);
    drain();
    check("lb_signed", last_rdata, 32'hFFFFFF80);
    issue(0, 2'd0, 1, 32'h43, 32'h0, 1);
    drain();
    check("lbu", last_rdata, 32'h00000080);
    issue(0, 2'd1, 0, 32'h42, 32'h0, 1);
    drain();
    check("lh_signed", last_rdata, 32'hFFFF8022);

    issue(0, 2'd1, 0, 32'h41, 32'h0, 1);
    issue(1, 2'd2, 0, 32'h42, 32'h5, 1);
    issue(0, 2'd3, 0, 32'h40, 32'h0, 1);
    issue(0, 2'd2, 0, 32'h1000, 32'h0, 1);
    drain();

    // Reset landing in the WRITE cycle of a sub-word store.
    saved = mem[20];
    issue(1, 2'd0, 0, 32'h51, 32'h5A, 0);
    check("rmw_read_cycle", 32'(mem_ren), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("rst_kills_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    check("mem_unchanged", mem[20], saved);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a | 32'h1000;
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("mem_image", 32'(nbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Clock and reset: clk, rising-edge; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data; the active bits are LSB-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load result.
REQ-013 resp_err  output  1  request rejected with no memory access.
REQ-014 mem_addr  output  10  word address to data memory, equal to req_addr[11:2].
REQ-015 mem_din  output  32  write word to data memory.
REQ-016 mem_wen  output  1  memory write enable, committed on the clk rising edge.
REQ-017 mem_ren  output  1  memory read enable.
REQ-018 mem_dout  input  32  memory read word, valid in the same cycle that mem_ren is high.

Function
REQ-019 The FSM SHALL have four states: IDLE, READ, WRITE and RESP. req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with req_valid=1, the unit SHALL latch the we, size, unsigned, addr and wdata fields on the clock edge.
REQ-021 The error condition is any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]≠0; addr[31:12]≠0. On error the next state SHALL be RESP with resp_err=1, and no mem_ren or mem_wen SHALL be asserted.
REQ-022 IDLE SHALL go to WRITE for a word store, and to READ for any load or sub-word store.
REQ-023 READ SHALL assert mem_ren=1, drive mem_addr, and capture mem_dout into an internal word buffer at the cycle end. The next state SHALL be RESP for a load and WRITE for a sub-word store.
REQ-024 WRITE SHALL assert mem_wen=1 for exactly one cycle. The next state SHALL be RESP.
REQ-025 Word store: mem_din SHALL equal wdata.
REQ-026 Halfword store: mem_din SHALL equal the buffer with lane addr[1] (bits [16·addr[1]+15 : 16·addr[1]]) replaced by wdata[15:0].
REQ-027 Byte store: mem_din SHALL equal the buffer with lane addr[1:0] (bits [8k+7 : 8k]) replaced by wdata[7:0].
REQ-028 Byte lanes are little-endian: byte k of a word occupies bits [8k+7 : 8k].
REQ-029 Load extraction SHALL select the byte or halfword lane from the buffer and extend it to 32 bits per req_unsigned. A word load SHALL return the buffer unchanged.
REQ-030 RESP SHALL assert resp_valid=1 for one cycle, then go to IDLE. resp_rdata SHALL be 0 for stores and for errors.
REQ-031 Latency from the acceptance edge to resp_valid: error 1 cycle; load 2; word store 2; sub-word store 3.
REQ-032 Outside READ and WRITE, mem_ren=0 and mem_wen=0. mem_addr SHALL hold the latched word address from acceptance until the next acceptance.
REQ-033 Throughput: a new request SHALL NOT be accepted in the RESP cycle. Back-to-back requests are therefore spaced by latency+1 cycles.
REQ-034 resp_valid SHALL NOT depend on any downstream ready signal; the consumer must take the response in its pulse cycle.

Reset
REQ-035 While reset=1, mem_wen and mem_ren SHALL be forced to 0 combinationally, including mid-operation in READ or WRITE.
REQ-036 On a clock edge with reset=1, the state SHALL become IDLE, and resp_valid, resp_err, resp_rdata, mem_addr, mem_din and the buffer SHALL all become 0. Any in-flight request SHALL be dropped with no response.
REQ-037 In the first cycle after reset deasserts, req_ready SHALL be 1.

Verification
REQ-038 Store word 0x11223344 to addr 0x40, then load word from 0x40. Required: mem_wen is asserted at mem_addr 16 with mem_din 0x11223344; the load returns 0x11223344 with resp_valid 2 cycles after acceptance.
REQ-039 Store byte 0xAB to addr 0x42 over stored word 0x11223344. Required: a READ cycle, then a WRITE cycle with mem_din 0x11AB3344; resp_valid 3 cycles after acceptance.
REQ-040 Load from addr 0x43 over word 0x80223344. Signed byte load SHALL return 0xFFFFFF80; unsigned byte load SHALL return 0x00000080. Signed halfword load from 0x42 SHALL return 0xFFFF8022.
REQ-041 Issue halfword load at addr 0x41, word store at addr 0x42, size=11, and addr 0x1000. Required for each: resp_err=1 one cycle after acceptance, with mem_ren=0 and mem_wen=0 throughout.
REQ-042 Assert reset during the WRITE cycle of a sub-word store. Required: mem_wen stays 0, the memory word is unchanged, no resp_valid is produced, and req_ready=1 in the cycle after reset deasserts.
